// File: rtl/ascii_line_sender.sv
// Snapshots a packed digit bus on start and streams PREFIX, grouped digits and a line terminator to a UART, one byte per handshake.
// First tx_start 2 cycles after start; each character waits for tx_busy low, then for the UART to take it (or ACK_TO), then for tx_busy low again.
module ascii_line_sender #(
  parameter logic [127:0] PREFIX     = "TIME = ",
  parameter int           PREFIX_LEN = 7,
  parameter int           N_DIGITS   = 8,
  parameter int           GROUP      = 2,
  parameter logic [7:0]   SEP        = ":",
  parameter bit           CRLF_EN    = 1'b0,
  parameter bit           HEX_EN     = 1'b0,
  parameter bit           LZB_EN     = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic                  tx_busy,
  output logic                  tx_start,
  output logic [7:0]            tx_data,
  output logic                  busy,
  output logic                  done
);

  localparam int NSEP   = (GROUP == 0) ? 0 : (N_DIGITS - 1) / GROUP;
  localparam int LEN    = PREFIX_LEN + N_DIGITS + NSEP + (CRLF_EN ? 2 : 1);
  localparam int IW     = $clog2(LEN + 1);
  localparam int GDIV   = (GROUP == 0) ? 1 : GROUP;
  localparam int ACK_TO = 4;
  localparam logic [IW-1:0] LAST = IW'(LEN - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_TX} state_t;

  state_t                state, state_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [4*N_DIGITS-1:0] snap, snap_nxt;
  logic [1:0]            ack_cnt, ack_nxt;
  logic                  tx_start_nxt, done_nxt;
  logic [7:0]            tx_data_nxt;
  logic [7:0]            cur_char;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    if (d < 4'd10)
      return 8'h30 + {4'h0, d};
    else if (HEX_EN)
      return 8'h41 + {4'h0, d - 4'd10};
    else
      return 8'h3F;
  endfunction

  // Character at the current index; separators are counted from the least significant digit.
  always_comb begin
    int         pos;
    int         kn;
    logic       lead;
    logic [3:0] nib;
    logic [3:0] nxt;
    cur_char = 8'h00;
    pos      = PREFIX_LEN;
    lead     = LZB_EN;
    nib      = 4'h0;
    nxt      = 4'h0;
    kn       = 0;
    for (int i = 0; i < PREFIX_LEN; i++) begin
      if (int'(idx) == i) cur_char = PREFIX[8*(PREFIX_LEN-1-i) +: 8];
    end
    for (int k = 0; k < N_DIGITS; k++) begin
      nib = snap[4*(N_DIGITS-1-k) +: 4];
      if (nib != 4'h0 || k == N_DIGITS - 1) lead = 1'b0;
      if (int'(idx) == pos) cur_char = lead ? 8'h20 : digit_char(nib);
      pos = pos + 1;
      if (GROUP != 0 && k < N_DIGITS - 1 && ((N_DIGITS - 1 - k) % GDIV) == 0) begin
        kn  = (k + 1 < N_DIGITS) ? k + 1 : k;
        nxt = snap[4*(N_DIGITS-1-kn) +: 4];
        // blank the separator only when the digit after it is blanked too
        if (int'(idx) == pos)
          cur_char = (lead && nxt == 4'h0 && kn != N_DIGITS - 1) ? 8'h20 : SEP;
        pos = pos + 1;
      end
    end
    if (CRLF_EN) begin
      if (int'(idx) == pos)     cur_char = 8'h0D;
      if (int'(idx) == pos + 1) cur_char = 8'h0A;
    end else begin
      if (int'(idx) == pos)     cur_char = 8'h0A;
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    snap_nxt     = snap;
    ack_nxt      = ack_cnt;
    tx_start_nxt = 1'b0;
    tx_data_nxt  = tx_data;
    done_nxt     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          snap_nxt  = digits;
          idx_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!tx_busy) begin
          tx_data_nxt  = cur_char;
          tx_start_nxt = 1'b1;
          ack_nxt      = 2'd0;
          state_nxt    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (tx_busy || ack_cnt == 2'(ACK_TO - 1))
          state_nxt = WAIT_TX;
        else
          ack_nxt = ack_cnt + 2'd1;
      end
      WAIT_TX: begin
        if (!tx_busy) begin
          if (idx == LAST) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            idx_nxt   = idx + IW'(1);
            state_nxt = ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      idx      <= '0;
      snap     <= '0;
      ack_cnt  <= 2'd0;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      done     <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      snap     <= snap_nxt;
      ack_cnt  <= ack_nxt;
      tx_start <= tx_start_nxt;
      tx_data  <= tx_data_nxt;
      done     <= done_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule
